serial_tx_fifo: RTL and testbench

Parametrised next-generation serial transmitter for the EMC08 serial block. It replaces the single-byte SBUF transmit path with a FIFO-buffered frame engine. Data width and FIFO depth are configurable, and the 9th bit and two stop bits are selectable per frame. Bit timing comes from the existing baud-rate tick; frames run back-to-back with no idle gap while the FIFO holds data.

---
 rtl/serial_tx_fifo_if.sv | 42 ++++
 rtl/serial_tx_fifo.sv | 153 +++++++++++++++
 tb/tb_serial_tx_fifo.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_tx_fifo_if.sv
// rtl/serial_tx_fifo_if.sv - handshake/status bundle for the FIFO-buffered serial transmitter
// Purpose: groups the tick, write, frame-control and status signals of serial_tx_fifo.
// Ports (via modports):
//   master drives serial_br_i, serial_wr_i, serial_data_i, serial_bit9_i, serial_mode9_i,
//          serial_stop2_i and serial_ti_clr_i, and observes the status outputs
//   slave  is the transmitter side: consumes the inputs and drives serial_data_tx_o,
//          serial_busy_o, serial_ti_o, serial_full_o, serial_empty_o, serial_level_o
//          and serial_ovf_o
interface serial_tx_fifo_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
);
  logic              serial_br_i;
  logic              serial_wr_i;
  logic [DATA_W-1:0] serial_data_i;
  logic              serial_bit9_i;
  logic              serial_mode9_i;
  logic              serial_stop2_i;
  logic              serial_ti_clr_i;
  logic              serial_data_tx_o;
  logic              serial_busy_o;
  logic              serial_ti_o;
  logic              serial_full_o;
  logic              serial_empty_o;
  logic [LVL_W-1:0]  serial_level_o;
  logic              serial_ovf_o;

  modport master (
    output serial_br_i, serial_wr_i, serial_data_i, serial_bit9_i,
           serial_mode9_i, serial_stop2_i, serial_ti_clr_i,
    input  serial_data_tx_o, serial_busy_o, serial_ti_o, serial_full_o,
           serial_empty_o, serial_level_o, serial_ovf_o
  );

  modport slave (
    input  serial_br_i, serial_wr_i, serial_data_i, serial_bit9_i,
           serial_mode9_i, serial_stop2_i, serial_ti_clr_i,
    output serial_data_tx_o, serial_busy_o, serial_ti_o, serial_full_o,
           serial_empty_o, serial_level_o, serial_ovf_o
  );
endinterface

// File: rtl/serial_tx_fifo.sv
// rtl/serial_tx_fifo.sv - FIFO-buffered serial frame transmitter
// Purpose: queues {bit9, data} entries and sends them as start/data/[bit9]/stop/[stop]
//          frames, one bit per baud tick, back-to-back while the FIFO holds data.
// Ports:
//   serial_clock_i  system clock
//   serial_reset_i  synchronous active-high reset
//   bus             serial_tx_fifo_if slave: tick, write port, frame control, status
module serial_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             serial_clock_i,
  input  logic             serial_reset_i,
  serial_tx_fifo_if.slave  bus
);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, BIT9, STOP1, STOP2} state_t;

  state_t            state_q, state_d;
  logic [DATA_W:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level_q;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bit9_q, bit9_d;
  logic              mode9_q, mode9_d;
  logic              stop2_q, stop2_d;
  logic              tx_q, tx_d;
  logic              ti_q, ovf_q;
  logic              full, empty, push, pop, frame_end;

  // full/empty come from the registered level, so a write in the same cycle as a
  // pop still sees the pre-cycle full flag and is dropped.
  assign full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty = (level_q == '0);
  assign push  = bus.serial_wr_i && !full;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    bit9_d    = bit9_q;
    mode9_d   = mode9_q;
    stop2_d   = stop2_q;
    pop       = 1'b0;
    frame_end = 1'b0;
    tx_d      = 1'b1;

    if (bus.serial_br_i) begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = START;
          end
        end
        START: begin
          state_d = DATA;
          cnt_d   = '0;
        end
        DATA: begin
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) state_d = mode9_q ? BIT9 : STOP1;
        end
        BIT9:  state_d = STOP1;
        STOP1: begin
          if (stop2_q) state_d = STOP2;
          else         frame_end = 1'b1;
        end
        STOP2:   frame_end = 1'b1;
        default: state_d = IDLE;
      endcase
    end

    // Frame end chains straight into the next start bit when data is waiting.
    if (frame_end) begin
      if (!empty) begin
        pop     = 1'b1;
        state_d = START;
      end else begin
        state_d = IDLE;
      end
    end

    // Frame options are captured with the entry so they stay fixed for the whole frame.
    if (pop) begin
      shift_d = mem[rd_ptr][DATA_W-1:0];
      bit9_d  = mem[rd_ptr][DATA_W];
      mode9_d = bus.serial_mode9_i;
      stop2_d = bus.serial_stop2_i;
    end

    // Line value is computed for the next state so tx moves together with the state.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      BIT9:    tx_d = bit9_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge serial_clock_i) begin
    if (push) mem[wr_ptr] <= {bus.serial_bit9_i, bus.serial_data_i};
  end

  always_ff @(posedge serial_clock_i) begin
    if (serial_reset_i) begin
      state_q <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      bit9_q  <= 1'b0;
      mode9_q <= 1'b0;
      stop2_q <= 1'b0;
      tx_q    <= 1'b1;
      ti_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      bit9_q  <= bit9_d;
      mode9_q <= mode9_d;
      stop2_q <= stop2_d;
      tx_q    <= tx_d;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
      if (frame_end)                ti_q <= 1'b1;
      else if (bus.serial_ti_clr_i) ti_q <= 1'b0;
      if (bus.serial_wr_i && full) ovf_q <= 1'b1;
    end
  end

  assign bus.serial_data_tx_o = tx_q;
  assign bus.serial_busy_o    = (state_q != IDLE);
  assign bus.serial_ti_o      = ti_q;
  assign bus.serial_full_o    = full;
  assign bus.serial_empty_o   = empty;
  assign bus.serial_level_o   = level_q;
  assign bus.serial_ovf_o     = ovf_q;
endmodule

// File: tb/tb_serial_tx_fifo.sv
// tb/tb_serial_tx_fifo.sv - directed scoreboard bench for serial_tx_fifo
module tb_serial_tx_fifo;
  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic sb [$];
  logic mon_en = 1'b0;
  logic prev_tx, prev_busy;

  serial_tx_fifo_if bus ();

  serial_tx_fifo dut (
    .serial_clock_i (clk),
    .serial_reset_i (rst),
    .bus            (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected line bits for one frame, using the frame options currently driven.
  task automatic push_frame(input logic [7:0] d);
    sb.push_back(1'b0);
    for (int i = 0; i < 8; i++) sb.push_back(d[i]);
    if (bus.serial_mode9_i) sb.push_back(bus.serial_bit9_i);
    sb.push_back(1'b1);
    if (bus.serial_stop2_i) sb.push_back(1'b1);
  endtask

  // All stimulus tasks are entered and left on a falling edge.
  task automatic wr_byte(input logic [7:0] d);
    bus.serial_wr_i   = 1'b1;
    bus.serial_data_i = d;
    push_frame(d);
    @(negedge clk);
    bus.serial_wr_i   = 1'b0;
  endtask

  task automatic tick(input int p);
    bus.serial_br_i = 1'b1;
    @(negedge clk);
    bus.serial_br_i = 1'b0;
    repeat (p - 1) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (sb.size() > 0 || bus.serial_busy_o); i++) tick(16);
    chk("drain_left", sb.size(), 0);
    chk("drain_busy", bus.serial_busy_o, 0);
  endtask

  // Line monitor: on every tick edge the bit that just ended is popped and compared.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (bus.serial_data_tx_o !== prev_tx) chk("tx_on_tick", bus.serial_br_i | rst, 1);
        if (bus.serial_br_i && prev_busy && !rst) begin
          total++;
          assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL extra_bit got=%0b exp=none", prev_tx);
          end
          if (sb.size() != 0) chk("line_bit", prev_tx, sb.pop_front());
          if (sb.size() != 0) chk("contiguous", bus.serial_busy_o, 1);
        end
      end
      prev_tx   = bus.serial_data_tx_o;
      prev_busy = bus.serial_busy_o;
    end
  end

  initial begin
    logic [7:0] v3 [4];
    logic [7:0] v4 [4];
    logic [7:0] v6 [3];
    v3 = '{8'h3C, 8'hC3, 8'h01, 8'h80};
    v4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    v6 = '{8'hF0, 8'h0F, 8'hAA};
    rst = 1'b1;
    bus.serial_br_i = 1'b0;
    bus.serial_wr_i = 1'b0;
    bus.serial_data_i = '0;
    bus.serial_bit9_i = 1'b0;
    bus.serial_mode9_i = 1'b0;
    bus.serial_stop2_i = 1'b0;
    bus.serial_ti_clr_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", bus.serial_data_tx_o, 1);
    chk("rst_busy", bus.serial_busy_o, 0);
    chk("rst_ti", bus.serial_ti_o, 0);
    chk("rst_full", bus.serial_full_o, 0);
    chk("rst_empty", bus.serial_empty_o, 1);
    chk("rst_level", bus.serial_level_o, 0);
    chk("rst_ovf", bus.serial_ovf_o, 0);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // Single 8N1 frame
    wr_byte(8'hA5);
    chk("t1_level", bus.serial_level_o, 1);
    chk("t1_empty", bus.serial_empty_o, 0);
    drain();
    chk("t1_ti", bus.serial_ti_o, 1);
    chk("t1_empty_end", bus.serial_empty_o, 1);
    chk("t1_ovf", bus.serial_ovf_o, 0);

    // 9th bit plus two stop bits; ti only after the second stop bit
    bus.serial_ti_clr_i = 1'b1;
    @(negedge clk);
    bus.serial_ti_clr_i = 1'b0;
    chk("t2_ti_clr", bus.serial_ti_o, 0);
    bus.serial_mode9_i = 1'b1;
    bus.serial_stop2_i = 1'b1;
    bus.serial_bit9_i  = 1'b1;
    wr_byte(8'h00);
    repeat (12) tick(16);
    chk("t2_ti_early", bus.serial_ti_o, 0);
    chk("t2_busy_stop2", bus.serial_busy_o, 1);
    tick(16);
    chk("t2_ti", bus.serial_ti_o, 1);
    chk("t2_busy_end", bus.serial_busy_o, 0);
    chk("t2_bits_left", sb.size(), 0);

    // Fill to full, then contiguous frames
    bus.serial_mode9_i = 1'b0;
    bus.serial_stop2_i = 1'b0;
    bus.serial_bit9_i  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_byte(v3[i]);
      chk("t3_level", bus.serial_level_o, i + 1);
    end
    chk("t3_full", bus.serial_full_o, 1);
    drain();
    chk("t3_empty", bus.serial_empty_o, 1);
    chk("t3_level_end", bus.serial_level_o, 0);

    // Write while full in the same cycle as a pop: write is dropped
    for (int i = 0; i < 4; i++) wr_byte(v4[i]);
    chk("t4_full", bus.serial_full_o, 1);
    chk("t4_ovf_pre", bus.serial_ovf_o, 0);
    bus.serial_wr_i   = 1'b1;
    bus.serial_data_i = 8'h77;
    bus.serial_br_i   = 1'b1;
    @(negedge clk);
    bus.serial_wr_i   = 1'b0;
    bus.serial_br_i   = 1'b0;
    chk("t4_ovf", bus.serial_ovf_o, 1);
    chk("t4_level", bus.serial_level_o, 3);
    chk("t4_busy", bus.serial_busy_o, 1);
    drain();
    chk("t4_ovf_sticky", bus.serial_ovf_o, 1);

    // ti set beats ti clear in the same cycle
    bus.serial_ti_clr_i = 1'b1;
    @(negedge clk);
    bus.serial_ti_clr_i = 1'b0;
    chk("t5_ti_clr", bus.serial_ti_o, 0);
    wr_byte(8'h5A);
    repeat (10) tick(4);
    chk("t5_ti_before", bus.serial_ti_o, 0);
    bus.serial_br_i     = 1'b1;
    bus.serial_ti_clr_i = 1'b1;
    @(negedge clk);
    bus.serial_br_i     = 1'b0;
    chk("t5_ti_set_wins", bus.serial_ti_o, 1);
    @(negedge clk);
    bus.serial_ti_clr_i = 1'b0;
    chk("t5_ti_cleared", bus.serial_ti_o, 0);

    // Reset in the middle of a data bit with two entries queued
    for (int i = 0; i < 3; i++) wr_byte(v6[i]);
    repeat (3) tick(4);
    chk("t6_level_pre", bus.serial_level_o, 2);
    chk("t6_busy_pre", bus.serial_busy_o, 1);
    chk("t6_tx_pre", bus.serial_data_tx_o, 0);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("t6_tx", bus.serial_data_tx_o, 1);
    chk("t6_level", bus.serial_level_o, 0);
    chk("t6_empty", bus.serial_empty_o, 1);
    chk("t6_busy", bus.serial_busy_o, 0);
    chk("t6_ti", bus.serial_ti_o, 0);
    chk("t6_ovf", bus.serial_ovf_o, 0);
    repeat (5) tick(16);
    chk("t6_tx_quiet", bus.serial_data_tx_o, 1);
    chk("t6_busy_quiet", bus.serial_busy_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
